// File: rtl/excess3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// excess3_seq_ctrl
//
// Sequential excess-3 to BCD word converter. A word of NDIG packed excess-3
// digits is accepted, converted one digit per cycle through a single shared
// 4-bit converter, and presented as packed BCD until the consumer takes it.
//
// Optional feature macro: EXCESS3_ERR_CHK_EN
//   defined   -> per-digit invalid-code detection (codes 0..2 and 13..15)
//   undefined -> out_err / out_err_pos tied to 0, no detection logic built
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both 1. A producer holds its payload stable while valid=1 and ready=0;
// valid never waits on ready (no combinational path from ready to valid).
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_word      in   [4*NDIG-1:0] excess-3 digits, digit 0 in [3:0]
//   in_valid     in   in_word is valid
//   in_ready     out  block can accept a word (IDLE only, 0 during reset)
//   out_bcd      out  [4*NDIG-1:0] BCD result, digit 0 in [3:0]
//   out_valid    out  out_bcd / out_err / out_err_pos are valid (HOLD)
//   out_ready    in   consumer accepts the result
//   out_err      out  at least one digit was an invalid code
//   out_err_pos  out  [NDIG-1:0] bit i set when digit i was invalid
//   busy         out  FSM is not in IDLE
//   dbg_state    out  [1:0] current FSM state (0 IDLE, 1 CONV, 2 HOLD)
// -----------------------------------------------------------------------------
module excess3_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   in_word,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_err,
    output logic [NDIG-1:0]     out_err_pos,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Counter is one bit wider than needed to index the digits so that the
    // post-increment on the last digit never wraps.
    localparam int CW = $clog2(NDIG) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CW-1:0]     cnt_q;
    logic [4*NDIG-1:0] word_q;
    logic [4*NDIG-1:0] result_q;
    logic              run_q;
    logic [3:0]        cur_dig;
    logic [3:0]        conv_bcd;
    logic              accept;
    logic              handshake;
    logic              last_dig;

    // -------------------------------------------------------------------------
    // run_q keeps in_ready low while reset is asserted and for the edge on
    // which it is released; acceptance opens from the following cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign in_ready  = run_q && (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign out_bcd   = result_q;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign last_dig  = (cnt_q == CW'(NDIG - 1));

    // -------------------------------------------------------------------------
    // Digit select: the latched word feeds the shared converter one digit at
    // a time, chosen by the counter.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_dig = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                cur_dig = word_q[4*i +: 4];
            end
        end
    end

    // -------------------------------------------------------------------------
    // The one shared excess-3 to BCD converter. These equations are kept
    // literally so invalid codes map to a deterministic (non-BCD) value.
    // -------------------------------------------------------------------------
    assign conv_bcd[0] = ~cur_dig[0];
    assign conv_bcd[1] = cur_dig[0] ^ cur_dig[1];
    assign conv_bcd[2] = (cur_dig[0] & cur_dig[1] & cur_dig[2])
                       | (~cur_dig[1] & ~cur_dig[2])
                       | (~cur_dig[2] & ~cur_dig[0]);
    assign conv_bcd[3] = (cur_dig[0] & cur_dig[1] & cur_dig[3])
                       | (cur_dig[3] & cur_dig[2]);

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (last_dig) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: the input word is captured once at accept, so later activity
    // on in_word / in_valid cannot disturb the word in progress. The result
    // register is only written during CONV, so it keeps its value in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            word_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            word_q   <= in_word;
            result_q <= '0;
        end else if (state_q == S_CONV) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cnt_q == CW'(i)) begin
                    result_q[4*i +: 4] <= conv_bcd;
                end
            end
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Optional invalid-code detection. The converted value is still written
    // for a bad digit; detection only records where the bad digits were.
    // -------------------------------------------------------------------------
`ifdef EXCESS3_ERR_CHK_EN
    logic [NDIG-1:0] err_pos_q;
    logic            dig_bad;

    assign dig_bad = (cur_dig <= 4'h2) || (cur_dig >= 4'hD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pos_q <= '0;
        end else if (accept) begin
            err_pos_q <= '0;
        end else if (state_q == S_CONV) begin
            for (int i = 0; i < NDIG; i++) begin
                if (cnt_q == CW'(i)) begin
                    err_pos_q[i] <= dig_bad;
                end
            end
        end
    end

    assign out_err_pos = err_pos_q;
    assign out_err     = |err_pos_q;
`else
    assign out_err_pos = '0;
    assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_excess3_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_excess3_seq_ctrl
//
// Directed bench for excess3_seq_ctrl. Two instances: a 4-digit one for the
// word-level scenarios and a 1-digit one for the full 16-code sweep.
// Expected values are hand-computed constants; invalid-code expectations
// follow EXCESS3_ERR_CHK_EN.
// -----------------------------------------------------------------------------
module tb_excess3_seq_ctrl;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // --------------------------------------------------------- 4-digit DUT
    logic [15:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_bcd;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_err;
    logic [3:0]  out_err_pos;
    logic        busy;
    logic [1:0]  dbg_state;

    excess3_seq_ctrl #(.NDIG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_bcd     (out_bcd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_err     (out_err),
        .out_err_pos (out_err_pos),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // --------------------------------------------------------- 1-digit DUT
    logic [3:0] in_word1 = '0;
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [3:0] out_bcd1;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic       out_err1;
    logic [0:0] out_err_pos1;
    logic       busy1;
    logic [1:0] dbg_state1;

    excess3_seq_ctrl #(.NDIG(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_word     (in_word1),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .out_bcd     (out_bcd1),
        .out_valid   (out_valid1),
        .out_ready   (out_ready1),
        .out_err     (out_err1),
        .out_err_pos (out_err_pos1),
        .busy        (busy1),
        .dbg_state   (dbg_state1)
    );

    // ------------------------------------------------------------ scoreboard
    int n_err    = 0;
    int n_checks = 0;

    // Hand-derived converter output for every 4-bit code 0..F.
    logic [3:0] conv_tab [16] = '{4'h5, 4'h6, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                  4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a word, scramble the inputs after acceptance, count edges until
    // out_valid (accept edge included) and check the held result.
    task automatic run_word(input string tag, input logic [15:0] w,
                            input logic [15:0] exp_bcd, input logic [3:0] exp_pos);
        int edges;
        logic [3:0] pos_exp;
`ifdef EXCESS3_ERR_CHK_EN
        pos_exp = exp_pos;
`else
        pos_exp = 4'b0000;
`endif
        in_word  = w;
        in_valid = 1'b1;
        edges    = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
            if (edges == 1) begin
                chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_word  = 16'($urandom_range(0, 65535));
        end
        chk({tag, "_latency"}, 32'(edges), 32'd5);
        chk({tag, "_bcd"}, 32'(out_bcd), 32'(exp_bcd));
        chk({tag, "_err"}, 32'(out_err), 32'(|pos_exp));
        chk({tag, "_err_pos"}, 32'(out_err_pos), 32'(pos_exp));
    endtask

    task automatic finish_word(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int vhigh;
        logic bad;

        // Reset state, sampled while rst_n is still low.
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_pos", 32'(out_err_pos), 32'd0);
        chk("rst_in_ready1", 32'(in_ready1), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Basic word: digits 3,7,C,4 -> 0,4,9,1.
        run_word("w4c73", 16'h4C73, 16'h1940, 4'b0000);
        chk("w4c73_state_hold", 32'(dbg_state), 32'd2);
        finish_word("w4c73");
        chk("w4c73_bcd_kept", 32'(out_bcd), 32'h1940);

        // Invalid code F in digit 2 -> converted to C, flagged when enabled.
        run_word("w3f33", 16'h3F33, 16'h0C00, 4'b0100);
        finish_word("w3f33");

        // All-valid word after an error word: flags must be cleared.
        run_word("w5a98", 16'h5A98, 16'h2765, 4'b0000);

        // Consumer stalls 6 cycles in HOLD.
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stall_bcd", 32'(out_bcd), 32'h2765);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        finish_word("stall");

        // Back-to-back words with in_valid held high.
        in_word   = 16'h3333;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                               // accept 3333
        chk("stream_busy0", 32'(busy), 32'd1);
        in_word = 16'hCCCC;
        for (int i = 0; i < 4; i++) tick();   // CONV
        chk("stream_valid0", 32'(out_valid), 32'd1);
        chk("stream_bcd0", 32'(out_bcd), 32'h0000);
        tick();                               // output handshake
        chk("stream_gap_ready", 32'(in_ready), 32'd1);
        chk("stream_gap_valid", 32'(out_valid), 32'd0);
        tick();                               // accept CCCC
        chk("stream_busy1", 32'(busy), 32'd1);
        chk("stream_ready1", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stream_valid1", 32'(out_valid), 32'd1);
        chk("stream_bcd1", 32'(out_bcd), 32'h9999);
        tick();
        out_ready = 1'b0;
        chk("stream_end_ready", 32'(in_ready), 32'd1);

        // Reset in the second CONV cycle discards the word.
        in_word  = 16'h4567;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bcd", 32'(out_bcd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_back", 32'(in_ready), 32'd1);
        vhigh = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) vhigh++;
        end
        chk("midrst_no_valid", 32'(vhigh), 32'd0);
        run_word("w5678", 16'h5678, 16'h2345, 4'b0000);
        finish_word("w5678");

        // Single-digit sweep of all 16 codes.
        for (int c = 0; c < 16; c++) begin
`ifdef EXCESS3_ERR_CHK_EN
            bad = (c <= 2) || (c >= 13);
`else
            bad = 1'b0;
`endif
            in_word1  = 4'(c);
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            tick();
            chk($sformatf("n1_valid_%0d", c), 32'(out_valid1), 32'd1);
            chk($sformatf("n1_bcd_%0d", c), 32'(out_bcd1), 32'(conv_tab[c]));
            chk($sformatf("n1_err_%0d", c), 32'(out_err1), 32'(bad));
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end
        chk("n1_end_ready", 32'(in_ready1), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
